osc_rst_seq: RTL and testbench
==============================

// Module: osc_rst_seq
// PURPOSE
//   Parametrised reset sequencer and clock-enable divider for the PLL clock domain.
//   Holds the core in reset until the PLL lock has been stable for a programmed
//   number of cycles, then releases it, and re-enters reset if lock is lost.
//   Generates N_CH phase-aligned clock-enable strobes and toggle outputs.
//   Divide ratios can be reprogrammed at run time without glitches.
//   Sits directly after the PLL and feeds rst and the enables to the DSP datapath.
// PARAMETERS
//   N_CH        4                   number of divider channels (1..16)
//   DIV_W       8                   divider ratio width; period of channel i = div_i+1 cycles
//   STARTUP_W   4                   startup counter width; release after 2**STARTUP_W locked cycles
//   SYNC_STAGES 2                   synchroniser depth for pll_lock (>=2)
//   DIV_INIT    {N_CH{8'd0}}        N_CH*DIV_W reset divide values; channel i = bits [i*DIV_W +: DIV_W]
// PORTS
//   clk         in   1              PLL output clock (sole clock)
//   rst         in   1              asynchronous, active-high reset
//   pll_lock    in   1              PLL lock, asynchronous to clk
//   div_wr      in   1              write strobe for a divide ratio
//   div_ch      in   4              channel index for div_wr
//   div_val     in   DIV_W          new divide ratio
//   rst_out     out  1              core reset, active-high, deasserts synchronously
//   ce          out  N_CH           one-cycle clock-enable strobes
//   clkdiv      out  N_CH           square outputs; bit i toggles on each ce[i]
//   relock_cnt  out  8              saturating count of lock losses while in RUN
// BEHAVIOUR
//   Reset (rst=1, async): FSM=WAIT_LOCK; rst_out=1; ce=0; clkdiv=0; relock_cnt=0;
//     startup counter=0; divider counters=0; active and shadow ratios=DIV_INIT.
//   pll_lock passes through SYNC_STAGES flops to give lock_s; the synchroniser is also reset to 0.
//   FSM:
//     WAIT_LOCK: rst_out=1. When lock_s=1, clear the startup counter and go to COUNT.
//     COUNT: rst_out=1. The counter increments while lock_s=1.
//       If lock_s=0, go to WAIT_LOCK.
//       When the counter reaches all-ones with lock_s=1, go to RUN.
//     RUN: rst_out=0. If lock_s=0, go to WAIT_LOCK, increment relock_cnt (saturates at 255),
//       and register rst_out=1 on that edge.
//   Latency: if pll_lock rises and stays high, rst_out falls SYNC_STAGES+2**STARTUP_W+1 cycles later.
//   Glitch handling: a lock dropout shorter than one cycle that is not captured is ignored.
//     Any captured dropout restarts the full startup count.
//   Dividers, per channel i, only in RUN:
//     cnt_i counts 0..div_i and wraps to 0. ce[i]=1 in cycles where cnt_i==div_i.
//     The first RUN cycle has cnt_i=0 for all channels, so all channels are phase-aligned.
//     ce[i] is first high in RUN cycle index div_i (0-based).
//     div_i=0 means ce[i]=1 in every RUN cycle and clkdiv[i] toggles every cycle.
//     Outside RUN: cnt_i=0, ce=0, clkdiv=0.
//   Run-time reprogramming:
//     div_wr=1 with div_ch<N_CH writes div_val into shadow[div_ch]. Writes with div_ch>=N_CH are ignored.
//     The active ratio loads from shadow only on a wrap edge (ce[i]=1) or while not in RUN,
//       so a running period is never truncated.
//     If a write and a wrap of the same channel coincide, div_val goes straight into the
//       active ratio (and the shadow) on that edge.
//   ce and clkdiv are registered; there is no combinational path from inputs to outputs.
// TESTING
//   1 Lock at t0 with defaults -> rst_out=1 until t0+2+16+1 cycles, then 0; relock_cnt=0.
//   2 Lock drops for 3 cycles in COUNT at count 10 -> count restarts;
//     rst_out falls 2+16+1 cycles after lock returns.
//   3 DIV_INIT={3,2,1,0} (ch3..ch0) -> ce0 every cycle, ce1 every 2nd, ce2 every 3rd,
//     ce3 every 4th; first pulses at RUN cycles 0,1,2,3.
//   4 ch2=2; write div_val=5 at cnt=0 -> current period stays 3 cycles, next periods are 6.
//     Write coinciding with ce2 -> new period applies immediately.
//   5 Lock lost in RUN -> rst_out=1 within SYNC_STAGES+1 cycles; ce=0 and clkdiv=0;
//     relock_cnt=1. Repeat 300 times -> relock_cnt saturates at 255.
//   6 Assert rst mid-RUN -> all outputs at reset values immediately;
//     shadow restored to DIV_INIT; write to div_ch=N_CH has no effect.

Source files
------------

// File: rtl/osc_rst_seq.sv
// Reset sequencer and clock-enable divider for the PLL clock domain: holds rst_out until lock
// has been stable for 2**STARTUP_W cycles, then runs N_CH phase-aligned enable/toggle channels.
module osc_rst_seq #(
    parameter int                    N_CH        = 4,
    parameter int                    DIV_W       = 8,
    parameter int                    STARTUP_W   = 4,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [N_CH*DIV_W-1:0] DIV_INIT    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_lock,
    input  logic             div_wr,
    input  logic [3:0]       div_ch,
    input  logic [DIV_W-1:0] div_val,
    output logic             rst_out,
    output logic [N_CH-1:0]  ce,
    output logic [N_CH-1:0]  clkdiv,
    output logic [7:0]       relock_cnt
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        COUNT     = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [SYNC_STAGES-1:0]        sync_q, sync_d;
    logic                          lock_s;
    logic [STARTUP_W-1:0]          st_cnt_q, st_cnt_d;
    logic                          rst_out_q, rst_out_d;
    logic [7:0]                    relock_q, relock_d;

    logic [N_CH-1:0][DIV_W-1:0]    cnt_q, cnt_d;
    logic [N_CH-1:0][DIV_W-1:0]    div_q, div_d;
    logic [N_CH-1:0][DIV_W-1:0]    shadow_q, shadow_d;
    logic [N_CH-1:0]               ce_q, ce_d;
    logic [N_CH-1:0]               clkdiv_q, clkdiv_d;
    logic [N_CH-1:0]               wr_hit, wrap;
    logic                          in_run, run_nxt;

    assign lock_s = sync_q[SYNC_STAGES-1];
    assign sync_d = {sync_q[SYNC_STAGES-2:0], pll_lock};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= WAIT_LOCK;
            sync_q    <= '0;
            st_cnt_q  <= '0;
            rst_out_q <= 1'b1;
            relock_q  <= '0;
            cnt_q     <= '0;
            div_q     <= DIV_INIT;
            shadow_q  <= DIV_INIT;
            ce_q      <= '0;
            clkdiv_q  <= '0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            st_cnt_q  <= st_cnt_d;
            rst_out_q <= rst_out_d;
            relock_q  <= relock_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            shadow_q  <= shadow_d;
            ce_q      <= ce_d;
            clkdiv_q  <= clkdiv_d;
        end
    end

    // Any captured dropout sends us back through the full startup count.
    always_comb begin
        state_d  = state_q;
        st_cnt_d = st_cnt_q;
        relock_d = relock_q;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d  = COUNT;
                    st_cnt_d = '0;
                end
            end
            COUNT: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (st_cnt_q == '1) begin
                    state_d = RUN;
                end else begin
                    st_cnt_d = st_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    if (relock_q != 8'hFF) begin
                        relock_d = relock_q + 8'd1;
                    end
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
        rst_out_d = (state_d != RUN);
    end

    assign in_run  = (state_q == RUN);
    assign run_nxt = (state_d == RUN);

    // Outputs are computed from next-cycle counter/ratio so ce/clkdiv stay registered
    // yet line up with the cycle in which cnt equals the active ratio.
    always_comb begin
        wr_hit   = '0;
        wrap     = '0;
        shadow_d = shadow_q;
        div_d    = div_q;
        cnt_d    = '0;
        ce_d     = '0;
        clkdiv_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            wr_hit[i]   = div_wr && (div_ch == 4'(i));
            shadow_d[i] = wr_hit[i] ? div_val : shadow_q[i];
            wrap[i]     = in_run && (cnt_q[i] == div_q[i]);
            // Active ratio only changes at a period boundary, never mid-period.
            if (wrap[i] || !in_run) begin
                div_d[i] = shadow_d[i];
            end
            if (!run_nxt || !in_run || wrap[i]) begin
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
            ce_d[i]     = run_nxt && (cnt_d[i] == div_d[i]);
            clkdiv_d[i] = run_nxt && (clkdiv_q[i] ^ ce_d[i]);
        end
    end

    assign rst_out    = rst_out_q;
    assign ce         = ce_q;
    assign clkdiv     = clkdiv_q;
    assign relock_cnt = relock_q;

endmodule

// File: tb/tb_osc_rst_seq.sv
// Bench for osc_rst_seq: startup latency, dropout restart, divider patterns, reprogramming,
// relock counting/saturation and asynchronous reset, checked through expectation queues.
module tb_osc_rst_seq;
    localparam int                    N_CH     = 4;
    localparam int                    DIV_W    = 8;
    localparam logic [N_CH*DIV_W-1:0] DIV_INIT = {8'd3, 8'd2, 8'd1, 8'd0};
    localparam int                    LAT      = 2 + 16 + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             pll_lock;
    logic             div_wr;
    logic [3:0]       div_ch;
    logic [DIV_W-1:0] div_val;
    logic             rst_out;
    logic [N_CH-1:0]  ce;
    logic [N_CH-1:0]  clkdiv;
    logic [7:0]       relock_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int exp_relock = 0;
    int exp_lat_q[$];
    logic [N_CH-1:0] exp_ce_q[$];
    logic [N_CH-1:0] exp_cd_q[$];

    always #5 clk = ~clk;

    osc_rst_seq #(
        .N_CH(N_CH), .DIV_W(DIV_W), .STARTUP_W(4), .SYNC_STAGES(2), .DIV_INIT(DIV_INIT)
    ) dut (
        .clk(clk), .rst(rst), .pll_lock(pll_lock), .div_wr(div_wr), .div_ch(div_ch),
        .div_val(div_val), .rst_out(rst_out), .ce(ce), .clkdiv(clkdiv), .relock_cnt(relock_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_release(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (rst_out !== 1'b0 && n < 200);
    endtask

    task automatic lose_lock(output int n);
        pll_lock = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (rst_out !== 1'b1 && n < 20);
    endtask

    // Expected ce/clkdiv for RUN cycles 0..ncyc-1 with ratios {3,2,1,0}.
    task automatic push_pattern(input int ncyc);
        int d [N_CH];
        logic [N_CH-1:0] e;
        logic [N_CH-1:0] t;
        d = '{0, 1, 2, 3};
        t = '0;
        for (int k = 0; k < ncyc; k++) begin
            for (int i = 0; i < N_CH; i++) begin
                e[i] = ((k % (d[i] + 1)) == d[i]);
            end
            t = t ^ e;
            exp_ce_q.push_back(e);
            exp_cd_q.push_back(t);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pll_lock = 1'b0; div_wr = 1'b0; div_ch = '0; div_val = '0;
        repeat (3) step();
        n_cmp++; if (rst_out !== 1'b1) begin n_err++; $display("FAIL reset_rst_out: got %b want 1", rst_out); end
        n_cmp++; if (ce !== 4'h0) begin n_err++; $display("FAIL reset_ce: got %b want 0000", ce); end
        n_cmp++; if (clkdiv !== 4'h0) begin n_err++; $display("FAIL reset_clkdiv: got %b want 0000", clkdiv); end
        n_cmp++; if (relock_cnt !== 8'd0) begin n_err++; $display("FAIL reset_relock: got %0d want 0", relock_cnt); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_startup();
        int n, lat;
        repeat (4) step();
        n_cmp++; if (rst_out !== 1'b1) begin n_err++; $display("FAIL unlocked_rst_out: got %b want 1", rst_out); end
        n_cmp++; if (ce !== 4'h0) begin n_err++; $display("FAIL unlocked_ce: got %b want 0000", ce); end
        pll_lock = 1'b1;
        exp_lat_q.push_back(LAT);
        run_to_release(n);
        lat = exp_lat_q.pop_front();
        n_cmp++; if (n !== lat) begin n_err++; $display("FAIL startup_latency: got %0d want %0d", n, lat); end
        n_cmp++; if (relock_cnt !== 8'd0) begin n_err++; $display("FAIL startup_relock: got %0d want 0", relock_cnt); end
    endtask

    task automatic test_divide_pattern();
        int n, lat;
        logic [N_CH-1:0] e, c;
        lose_lock(n);
        exp_relock++;
        pll_lock = 1'b1;
        exp_lat_q.push_back(LAT);
        run_to_release(n);
        lat = exp_lat_q.pop_front();
        n_cmp++; if (n !== lat) begin n_err++; $display("FAIL pattern_latency: got %0d want %0d", n, lat); end
        push_pattern(24);
        for (int k = 0; exp_ce_q.size() > 0; k++) begin
            e = exp_ce_q.pop_front();
            c = exp_cd_q.pop_front();
            n_cmp++; if (ce !== e) begin n_err++; $display("FAIL pattern_ce cyc%0d: got %b want %b", k, ce, e); end
            n_cmp++; if (clkdiv !== c) begin n_err++; $display("FAIL pattern_clkdiv cyc%0d: got %b want %b", k, clkdiv, c); end
            step();
        end
    endtask

    task automatic test_reprogram();
        int n;
        logic e;
        logic q[$];
        // Write at cnt=0: current 3-cycle period completes, then 6-cycle periods.
        n = 0;
        while (ce[2] !== 1'b1 && n < 20) begin step(); n++; end
        n_cmp++; if (n >= 20) begin n_err++; $display("FAIL reprog_find_ce2: got timeout want ce2 pulse"); end
        step();
        div_wr = 1'b1; div_ch = 4'd2; div_val = 8'd5;
        for (int k = 0; k < 15; k++) q.push_back(k == 2 || k == 8 || k == 14);
        for (int k = 0; q.size() > 0; k++) begin
            e = q.pop_front();
            n_cmp++; if (ce[2] !== e) begin n_err++; $display("FAIL reprog_defer cyc%0d: got %b want %b", k, ce[2], e); end
            step();
            div_wr = 1'b0;
        end
        // Write landing on the wrap edge applies to the very next period.
        n = 0;
        while (ce[2] !== 1'b1 && n < 20) begin step(); n++; end
        n_cmp++; if (n >= 20) begin n_err++; $display("FAIL reprog_find_wrap: got timeout want ce2 pulse"); end
        div_wr = 1'b1; div_ch = 4'd2; div_val = 8'd1;
        step();
        div_wr = 1'b0;
        for (int k = 0; k < 6; k++) q.push_back(k % 2 == 1);
        for (int k = 0; q.size() > 0; k++) begin
            e = q.pop_front();
            n_cmp++; if (ce[2] !== e) begin n_err++; $display("FAIL reprog_wrap cyc%0d: got %b want %b", k, ce[2], e); end
            step();
        end
    endtask

    task automatic test_lock_loss();
        int n;
        lose_lock(n);
        exp_relock++;
        n_cmp++; if (n !== 3) begin n_err++; $display("FAIL loss_latency: got %0d want 3", n); end
        n_cmp++; if (ce !== 4'h0) begin n_err++; $display("FAIL loss_ce: got %b want 0000", ce); end
        n_cmp++; if (clkdiv !== 4'h0) begin n_err++; $display("FAIL loss_clkdiv: got %b want 0000", clkdiv); end
        n_cmp++; if (relock_cnt !== 8'(exp_relock)) begin n_err++; $display("FAIL loss_relock: got %0d want %0d", relock_cnt, exp_relock); end
        for (int r = 0; r < 300; r++) begin
            pll_lock = 1'b1;
            run_to_release(n);
            lose_lock(n);
            if (exp_relock < 255) exp_relock++;
            if (r == 50) begin
                n_cmp++; if (relock_cnt !== 8'(exp_relock)) begin n_err++; $display("FAIL relock_mid: got %0d want %0d", relock_cnt, exp_relock); end
            end
        end
        n_cmp++; if (relock_cnt !== 8'd255) begin n_err++; $display("FAIL relock_sat: got %0d want 255", relock_cnt); end
    endtask

    task automatic test_dropout();
        int n, lat;
        pll_lock = 1'b1;
        repeat (11) step();
        pll_lock = 1'b0;
        repeat (3) step();
        pll_lock = 1'b1;
        exp_lat_q.push_back(LAT);
        run_to_release(n);
        lat = exp_lat_q.pop_front();
        n_cmp++; if (n !== lat) begin n_err++; $display("FAIL dropout_latency: got %0d want %0d", n, lat); end
        n_cmp++; if (relock_cnt !== 8'd255) begin n_err++; $display("FAIL dropout_relock: got %0d want 255", relock_cnt); end
    endtask

    task automatic test_async_reset();
        int n, lat;
        logic [N_CH-1:0] e, c;
        div_wr = 1'b1; div_ch = 4'd0; div_val = 8'd7;
        step();
        div_wr = 1'b0;
        repeat (3) step();
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (rst_out !== 1'b1) begin n_err++; $display("FAIL arst_rst_out: got %b want 1", rst_out); end
        n_cmp++; if (ce !== 4'h0) begin n_err++; $display("FAIL arst_ce: got %b want 0000", ce); end
        n_cmp++; if (clkdiv !== 4'h0) begin n_err++; $display("FAIL arst_clkdiv: got %b want 0000", clkdiv); end
        n_cmp++; if (relock_cnt !== 8'd0) begin n_err++; $display("FAIL arst_relock: got %0d want 0", relock_cnt); end
        exp_relock = 0;
        repeat (2) step();
        rst = 1'b0;
        div_wr = 1'b1; div_ch = 4'(N_CH); div_val = 8'd9;
        exp_lat_q.push_back(LAT);
        step();
        div_wr = 1'b0;
        run_to_release(n);
        n++;
        lat = exp_lat_q.pop_front();
        n_cmp++; if (n !== lat) begin n_err++; $display("FAIL arst_latency: got %0d want %0d", n, lat); end
        push_pattern(12);
        for (int k = 0; exp_ce_q.size() > 0; k++) begin
            e = exp_ce_q.pop_front();
            c = exp_cd_q.pop_front();
            n_cmp++; if (ce !== e) begin n_err++; $display("FAIL arst_ce cyc%0d: got %b want %b", k, ce, e); end
            n_cmp++; if (clkdiv !== c) begin n_err++; $display("FAIL arst_clkdiv cyc%0d: got %b want %b", k, clkdiv, c); end
            step();
        end
        n_cmp++; if (relock_cnt !== 8'(exp_relock)) begin n_err++; $display("FAIL arst_relock_end: got %0d want %0d", relock_cnt, exp_relock); end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_divide_pattern();
        test_reprogram();
        test_lock_loss();
        test_dropout();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
